// File: rtl/shift_arb8_pkg.sv
// Shared constants, FSM state type and helpers for the shift_arb8 scheduler.
package shift_arb8_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned SHAMT_W = 3;
   localparam int unsigned ID_W    = 1;
   localparam int unsigned STAT_W  = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   typedef enum logic [1:0] {
      StIdle = S_IDLE,
      StExec = S_EXEC,
      StResp = S_RESP
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0]  din;
      logic [SHAMT_W-1:0] shamt;
      logic               lr;
      logic               al;
   } shift_op_t;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/barrel_shifter8.sv
// Combinational 8-bit log shifter: left zero fill, right logical or sign fill.
module barrel_shifter8
   import shift_arb8_pkg::*;
(
   input  logic [DATA_W-1:0]  din,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               lr,
   input  logic               al,
   output logic [DATA_W-1:0]  dout
);

   logic              fill;
   logic [DATA_W-1:0] acc;

   assign fill = al & din[DATA_W-1];

   // One stage per shamt bit, shifting by 1, 2, 4.
   always_comb begin
      acc = din;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (shamt[k]) begin
            if (lr) begin
               acc = acc << (1 << k);
            end else begin
               acc = (acc >> (1 << k)) |
                     (~({DATA_W{1'b1}} >> (1 << k)) & {DATA_W{fill}});
            end
         end
      end
      dout = acc;
   end

endmodule

// File: rtl/shift_arb8.sv
// Two-requester round-robin front end for one shared barrel_shifter8.
// Optional per-requester accept counters under `SHIFT_ARB8_STATS_EN.
module shift_arb8
   import shift_arb8_pkg::*;
#(
   parameter int unsigned DW = DATA_W,
   parameter int unsigned SW = SHAMT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DW-1:0]     req0_din,
   input  logic [SW-1:0]     req0_shamt,
   input  logic              req0_LR,
   input  logic              req0_AL,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DW-1:0]     req1_din,
   input  logic [SW-1:0]     req1_shamt,
   input  logic              req1_LR,
   input  logic              req1_AL,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [ID_W-1:0]   resp_id,
   output logic [DW-1:0]     resp_dout
`ifdef SHIFT_ARB8_STATS_EN
   ,
   output logic [STAT_W-1:0] stat0_cnt,
   output logic [STAT_W-1:0] stat1_cnt
`endif
);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [ID_W-1:0]   id_q, id_d;
   shift_op_t         op_q, op_d;
   logic [DW-1:0]     resp_dout_q, resp_dout_d;
   logic [ID_W-1:0]   resp_id_q, resp_id_d;
   logic              any_valid;
   logic              grant_id;
   logic              accept;
   logic [DATA_W-1:0] shift_dout;

   // On a tie the requester not served last wins; otherwise the lone valid one.
   assign any_valid = req0_valid | req1_valid;
   assign grant_id  = (req0_valid & req1_valid) ? ~last_q : req1_valid;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      op_d        = op_q;
      resp_dout_d = resp_dout_q;
      resp_id_d   = resp_id_q;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         StIdle: begin
            accept     = any_valid & ~rst;
            req0_ready = accept & ~grant_id;
            req1_ready = accept & grant_id;
            if (accept) begin
               state_d = StExec;
               id_d    = grant_id;
               last_d  = grant_id;
               if (grant_id) begin
                  op_d.din   = req1_din;
                  op_d.shamt = req1_shamt;
                  op_d.lr    = req1_LR;
                  op_d.al    = req1_AL;
               end else begin
                  op_d.din   = req0_din;
                  op_d.shamt = req0_shamt;
                  op_d.lr    = req0_LR;
                  op_d.al    = req0_AL;
               end
            end
         end
         StExec: begin
            resp_dout_d = shift_dout;
            resp_id_d   = id_q;
            state_d     = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         id_q        <= '0;
         op_q        <= '0;
         resp_dout_q <= '0;
         resp_id_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         op_q        <= op_d;
         resp_dout_q <= resp_dout_d;
         resp_id_q   <= resp_id_d;
      end
   end

   barrel_shifter8 u_shifter (
      .din   (op_q.din),
      .shamt (op_q.shamt),
      .lr    (op_q.lr),
      .al    (op_q.al),
      .dout  (shift_dout)
   );

   assign resp_valid = (state_q == StResp);
   assign resp_id    = resp_id_q;
   assign resp_dout  = resp_dout_q;

`ifdef SHIFT_ARB8_STATS_EN
   logic [STAT_W-1:0] stat0_q, stat0_d;
   logic [STAT_W-1:0] stat1_q, stat1_d;

   always_comb begin
      stat0_d = stat0_q;
      stat1_d = stat1_q;
      if (accept) begin
         if (grant_id) begin
            stat1_d = sat_inc(stat1_q);
         end else begin
            stat0_d = sat_inc(stat0_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat0_q <= '0;
         stat1_q <= '0;
      end else begin
         stat0_q <= stat0_d;
         stat1_q <= stat1_d;
      end
   end

   assign stat0_cnt = stat0_q;
   assign stat1_cnt = stat1_q;
`endif

endmodule
